// File: rtl/logic_pkg.sv
// logic_pkg: shared definitions for the logic_block command issuer.
//   - Opcode encodings understood by logic_block.
//   - op_legal(): true for the four opcodes logic_block implements.
//   - state_t: issuer FSM states.
package logic_pkg;

    localparam int LB_W = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND:  legal = 1'b1;
            OP_OR:   legal = 1'b1;
            OP_XOR:  legal = 1'b1;
            OP_NOT:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/logic_block.sv
// logic_block: fixed 16-bit combinational bitwise ALU slice.
// Ports:
//   a      in  16  operand A
//   b      in  16  operand B (unused for NOT)
//   sel    in  3   opcode (AND/OR/XOR/NOT A); unknown codes give 0
//   result out 16  bitwise result
module logic_block
    import logic_pkg::*;
(
    input  logic [LB_W-1:0] a,
    input  logic [LB_W-1:0] b,
    input  logic [2:0]      sel,
    output logic [LB_W-1:0] result
);

    // Bitwise operation select
    always_comb begin
        result = {LB_W{1'b0}};
        case (sel)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = {LB_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic_cmd_issuer.sv
// logic_cmd_issuer: command-side driver for the 16-bit logic_block slice.
// Accepts a command in IDLE, registers operands/select onto logic_block,
// captures its output one cycle later and presents it with zero/error flags
// until the consumer takes it. An accumulator holds the last legal result so
// that chained operations can reuse it as operand A.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b   opcode and operands
//   cmd_acc, cmd_clr       use accumulator as A / reload ACC_INIT at accept
//   rsp_valid/rsp_ready    response handshake
//   rsp_data, rsp_zero,
//   rsp_err                result, result==0, illegal opcode
//   busy                   FSM not in IDLE
module logic_cmd_issuer
    import logic_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] ACC_INIT = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_acc,
    input  logic              cmd_clr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
);

    // logic_block is a fixed-width slice; any other width cannot be wired up.
    if (DATA_W != LB_W) begin : g_bad_width
        $error("logic_cmd_issuer: DATA_W must be 16");
    end

    state_t            state_r;
    state_t            state_nx_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [2:0]        sel_r;
    logic              err_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] a_sel_s;
    logic [DATA_W-1:0] lb_out_s;
    logic [DATA_W-1:0] capt_s;
    logic              accept_s;
    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_zero_r;
    logic              rsp_err_r;
    logic              busy_r;

    logic_block u_logic (
        .a      (a_r),
        .b      (b_r),
        .sel    (sel_r),
        .result (lb_out_s)
    );

    // Next-state decode and accept qualification
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx_s = EXEC;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EXEC: state_nx_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Operand A source; cmd_clr makes the accumulator read as ACC_INIT
    always_comb begin
        a_sel_s = cmd_a;
        if (cmd_acc) begin
            if (cmd_clr) begin
                a_sel_s = ACC_INIT;
            end else begin
                a_sel_s = acc_r;
            end
        end else begin
            a_sel_s = cmd_a;
        end
    end

    // Illegal ops return zero regardless of what logic_block produces
    always_comb begin
        capt_s = lb_out_s;
        if (err_r) begin
            capt_s = {DATA_W{1'b0}};
        end else begin
            capt_s = lb_out_s;
        end
    end

    // FSM state, operand registers, accumulator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            sel_r       <= 3'b000;
            err_r       <= 1'b0;
            acc_r       <= ACC_INIT;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_zero_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cmd_ready_r <= (state_nx_s == IDLE);
            rsp_valid_r <= (state_nx_s == RESP);
            busy_r      <= (state_nx_s != IDLE);
            if (accept_s) begin
                a_r   <= a_sel_s;
                b_r   <= cmd_b;
                sel_r <= cmd_op;
                err_r <= !op_legal(cmd_op);
                if (cmd_clr) begin
                    acc_r <= ACC_INIT;
                end else begin
                    acc_r <= acc_r;
                end
            end else if (state_r == EXEC) begin
                rsp_data_r <= capt_s;
                rsp_zero_r <= (capt_s == {DATA_W{1'b0}});
                rsp_err_r  <= err_r;
                if (!err_r) begin
                    acc_r <= capt_s;
                end else begin
                    acc_r <= acc_r;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_zero  = rsp_zero_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule
